idli_ibuf_m: RTL and testbench

- Parametrised nibble-serial instruction assembler and buffer. Sits between the SQI fetch stream and decode.
- Gathers LANE_W-bit beats MSB-first into WORD_W-bit instruction words.
- Detects when a word is followed by an immediate and pairs the two into one entry. Queues up to DEPTH entries behind a valid/ready interface.
- Unlike the fixed 4b decoder, it generalises beat width, word width, queue depth and immediate-detect rule, and adds backpressure and flush.

---
 rtl/idli_ibuf_m.sv | 158 +++++++++++++++
 tb/tb_idli_ibuf_m.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_ibuf_m.sv
// Instruction assembler and queue: packs LANE_W-bit beats MSB-first into WORD_W-bit
// words, pairs a word with its trailing immediate, and buffers DEPTH entries.
module idli_ibuf_m #(
    parameter int unsigned LANE_W     = 4,
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned DEPTH      = 2,
    parameter logic [WORD_W-1:0] IMM_MASK   = 16'h0007,
    parameter logic [WORD_W-1:0] IMM_MATCH  = 16'h0007,
    parameter logic [WORD_W-1:0] EXCL_MASK  = 16'h0000,
    parameter logic [WORD_W-1:0] EXCL_MATCH = 16'h0001
) (
    input  logic                         i_ibf_gck,
    input  logic                         i_ibf_rst,
    input  logic [LANE_W-1:0]            i_ibf_beat,
    input  logic                         i_ibf_beat_vld,
    output logic                         o_ibf_beat_rdy,
    input  logic                         i_ibf_flush,
    output logic                         o_ibf_vld,
    input  logic                         i_ibf_rdy,
    output logic [WORD_W-1:0]            o_ibf_insn,
    output logic [WORD_W-1:0]            o_ibf_imm,
    output logic                         o_ibf_imm_vld,
    output logic [$clog2(DEPTH+1)-1:0]   o_ibf_cnt
);

    localparam int unsigned BEATS  = WORD_W / LANE_W;
    localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic {ASM_INSN, ASM_IMM} asm_e;

    asm_e               asm_q, asm_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [WORD_W-1:0]  part_q, part_d;
    logic [WORD_W-1:0]  held_q, held_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WORD_W-1:0]  insn_mem_q [DEPTH];
    logic [WORD_W-1:0]  imm_mem_q  [DEPTH];
    logic               immv_mem_q [DEPTH];

    logic [WORD_W-1:0]  word_c, push_insn_c, push_imm_c;
    logic               push_immv_c, last_c, need_imm_c, completing_c;
    logic               full_c, accept_c, push_c, pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes, assembly FSM and queue bookkeeping
    always_comb begin
        asm_d       = asm_q;
        bcnt_d      = bcnt_q;
        part_d      = part_q;
        held_d      = held_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        push_insn_c = '0;
        push_imm_c  = '0;
        push_immv_c = 1'b0;

        word_c       = (part_q << LANE_W) | WORD_W'(i_ibf_beat);
        last_c       = (bcnt_q == BCNT_W'(BEATS - 1));
        need_imm_c   = ((word_c & IMM_MASK) == IMM_MATCH) && !((word_c & EXCL_MASK) == EXCL_MATCH);
        completing_c = last_c && ((asm_q == ASM_IMM) || !need_imm_c);
        full_c       = (cnt_q == CNT_W'(DEPTH));

        o_ibf_beat_rdy = !i_ibf_flush && !(full_c && completing_c);
        o_ibf_vld      = (cnt_q != '0) && !i_ibf_flush;
        accept_c       = i_ibf_beat_vld && o_ibf_beat_rdy;
        push_c         = accept_c && completing_c;
        pop_c          = o_ibf_vld && i_ibf_rdy;

        if (accept_c) begin
            if (last_c) begin
                bcnt_d = '0;
                part_d = '0;
                unique case (asm_q)
                    ASM_INSN: begin
                        push_insn_c = word_c;
                        if (need_imm_c) begin
                            held_d = word_c;
                            asm_d  = ASM_IMM;
                        end
                    end
                    ASM_IMM: begin
                        push_insn_c = held_q;
                        push_imm_c  = word_c;
                        push_immv_c = 1'b1;
                        asm_d       = ASM_INSN;
                    end
                    default: asm_d = ASM_INSN;
                endcase
            end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
                part_d = word_c;
            end
        end

        if (push_c) wr_d = ptr_inc(wr_q);
        if (pop_c)  rd_d = ptr_inc(rd_q);
        unique case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Redirect drops all in-flight progress and every queued entry
        if (i_ibf_flush) begin
            asm_d  = ASM_INSN;
            bcnt_d = '0;
            part_d = '0;
            held_d = '0;
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge i_ibf_gck) begin
        if (i_ibf_rst) begin
            asm_q  <= ASM_INSN;
            bcnt_q <= '0;
            part_q <= '0;
            held_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                insn_mem_q[i] <= '0;
                imm_mem_q[i]  <= '0;
                immv_mem_q[i] <= 1'b0;
            end
        end else begin
            asm_q  <= asm_d;
            bcnt_q <= bcnt_d;
            part_q <= part_d;
            held_q <= held_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            if (push_c) begin
                insn_mem_q[wr_q] <= push_insn_c;
                imm_mem_q[wr_q]  <= push_imm_c;
                immv_mem_q[wr_q] <= push_immv_c;
            end
        end
    end

    assign o_ibf_insn    = insn_mem_q[rd_q];
    assign o_ibf_imm     = imm_mem_q[rd_q];
    assign o_ibf_imm_vld = immv_mem_q[rd_q];
    assign o_ibf_cnt     = cnt_q;

endmodule

// File: tb/tb_idli_ibuf_m.sv
// Bench for idli_ibuf_m: three configurations run side by side against a list-based
// reference model, with directed scenarios and a randomized soak.
module tb_idli_ibuf_m;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] beat [3];
    logic       bvld [3];
    logic       fl   [3];
    logic       rdy  [3];

    logic        o_rdy  [3];
    logic        o_vld  [3];
    logic        o_iv   [3];
    logic [15:0] o_insn [3];
    logic [15:0] o_imm  [3];
    logic [1:0]  ocnt   [3];
    logic [1:0]  cnt0, cnt1;
    logic        cnt2;

    int checks = 0;
    int errors = 0;

    // Per-instance configuration and reference model state
    int          lane  [3] = '{4, 4, 8};
    int          depth [3] = '{2, 2, 1};
    logic [15:0] em    [3] = '{16'h0000, 16'hF00F, 16'h0000};
    logic [15:0] ex    [3] = '{16'h0001, 16'hB00F, 16'h0001};
    logic [15:0] qi [3][4];
    logic [15:0] qm [3][4];
    logic        qv [3][4];
    int          mcnt [3];
    int          mb   [3];
    logic [15:0] mw   [3];
    logic [15:0] mh   [3];
    bit          mp   [3];

    always #5 clk = ~clk;

    idli_ibuf_m u0 (
        .i_ibf_gck(clk), .i_ibf_rst(rst), .i_ibf_beat(beat[0][3:0]), .i_ibf_beat_vld(bvld[0]),
        .o_ibf_beat_rdy(o_rdy[0]), .i_ibf_flush(fl[0]), .o_ibf_vld(o_vld[0]), .i_ibf_rdy(rdy[0]),
        .o_ibf_insn(o_insn[0]), .o_ibf_imm(o_imm[0]), .o_ibf_imm_vld(o_iv[0]), .o_ibf_cnt(cnt0));

    idli_ibuf_m #(.EXCL_MASK(16'hF00F), .EXCL_MATCH(16'hB00F)) u1 (
        .i_ibf_gck(clk), .i_ibf_rst(rst), .i_ibf_beat(beat[1][3:0]), .i_ibf_beat_vld(bvld[1]),
        .o_ibf_beat_rdy(o_rdy[1]), .i_ibf_flush(fl[1]), .o_ibf_vld(o_vld[1]), .i_ibf_rdy(rdy[1]),
        .o_ibf_insn(o_insn[1]), .o_ibf_imm(o_imm[1]), .o_ibf_imm_vld(o_iv[1]), .o_ibf_cnt(cnt1));

    idli_ibuf_m #(.LANE_W(8), .DEPTH(1)) u2 (
        .i_ibf_gck(clk), .i_ibf_rst(rst), .i_ibf_beat(beat[2]), .i_ibf_beat_vld(bvld[2]),
        .o_ibf_beat_rdy(o_rdy[2]), .i_ibf_flush(fl[2]), .o_ibf_vld(o_vld[2]), .i_ibf_rdy(rdy[2]),
        .o_ibf_insn(o_insn[2]), .o_ibf_imm(o_imm[2]), .o_ibf_imm_vld(o_iv[2]), .o_ibf_cnt(cnt2));

    assign ocnt[0] = cnt0;
    assign ocnt[1] = cnt1;
    assign ocnt[2] = {1'b0, cnt2};

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        mcnt[i] = 0;
        mb[i]   = 0;
        mw[i]   = '0;
        mh[i]   = '0;
        mp[i]   = 1'b0;
    endtask

    task automatic model_push(input int i, input logic [15:0] ins, input logic [15:0] im, input logic v);
        qi[i][mcnt[i]] = ins;
        qm[i][mcnt[i]] = im;
        qv[i][mcnt[i]] = v;
        mcnt[i]++;
    endtask

    // Compare one instance against the model for the current cycle, then advance the model
    task automatic model_cycle(input int i);
        int          bpw;
        logic [15:0] bm, wn;
        bit          last, need, comp, e_rdy, e_vld;
        bpw   = 16 / lane[i];
        bm    = 16'(beat[i]) & 16'((1 << lane[i]) - 1);
        wn    = 16'((mw[i] << lane[i]) | bm);
        last  = (mb[i] == bpw - 1);
        need  = ((wn & 16'h0007) == 16'h0007) && ((wn & em[i]) != ex[i]);
        comp  = last && (mp[i] || !need);
        e_rdy = !fl[i] && !((mcnt[i] == depth[i]) && comp);
        e_vld = (mcnt[i] != 0) && !fl[i];
        if (bvld[i]) chk("beat_rdy", i, 32'(o_rdy[i]), 32'(e_rdy));
        chk("vld", i, 32'(o_vld[i]), 32'(e_vld));
        chk("cnt", i, 32'(ocnt[i]), 32'(mcnt[i]));
        if (e_vld) begin
            chk("insn", i, 32'(o_insn[i]), 32'(qi[i][0]));
            chk("imm", i, 32'(o_imm[i]), 32'(qm[i][0]));
            chk("imm_vld", i, 32'(o_iv[i]), 32'(qv[i][0]));
        end
        if (fl[i]) begin
            model_reset(i);
            return;
        end
        if (e_vld && rdy[i]) begin
            for (int k = 0; k < 3; k++) begin
                qi[i][k] = qi[i][k+1];
                qm[i][k] = qm[i][k+1];
                qv[i][k] = qv[i][k+1];
            end
            mcnt[i]--;
        end
        if (bvld[i] && e_rdy) begin
            if (last) begin
                if (mp[i]) begin
                    model_push(i, mh[i], wn, 1'b1);
                    mp[i] = 1'b0;
                end else if (need) begin
                    mh[i] = wn;
                    mp[i] = 1'b1;
                end else begin
                    model_push(i, wn, 16'h0000, 1'b0);
                end
                mb[i] = 0;
                mw[i] = '0;
            end else begin
                mb[i]++;
                mw[i] = wn;
            end
        end
    endtask

    task automatic look();
        #2;
    endtask

    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            if (rst) model_reset(i);
            else     model_cycle(i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        look();
        tick();
    endtask

    task automatic send(input int i, input logic [7:0] v);
        bvld[i] = 1'b1;
        beat[i] = v;
        step();
        bvld[i] = 1'b0;
    endtask

    task automatic send_word(input int i, input logic [15:0] w);
        for (int k = 0; k < 16 / lane[i]; k++)
            send(i, 8'((w >> (16 - (k + 1) * lane[i])) & 16'((1 << lane[i]) - 1)));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat[i] = '0; bvld[i] = 1'b0; fl[i] = 1'b0; rdy[i] = 1'b0;
            model_reset(i);
        end
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        look();
        for (int i = 0; i < 3; i++) begin
            chk("rst_vld", i, 32'(o_vld[i]), 32'd0);
            chk("rst_cnt", i, 32'(ocnt[i]), 32'd0);
            chk("rst_insn", i, 32'(o_insn[i]), 32'd0);
            chk("rst_imm", i, 32'(o_imm[i]), 32'd0);
            chk("rst_imm_vld", i, 32'(o_iv[i]), 32'd0);
            chk("rst_beat_rdy", i, 32'(o_rdy[i]), 32'd1);
        end
        tick();

        // Plain word, then word + immediate
        rdy[0] = 1'b1;
        send(0, 8'hC); send(0, 8'h1); send(0, 8'h2); send(0, 8'h3);
        look();
        chk("t1_vld", 0, 32'(o_vld[0]), 32'd1);
        chk("t1_insn", 0, 32'(o_insn[0]), 32'hC123);
        chk("t1_imm_vld", 0, 32'(o_iv[0]), 32'd0);
        chk("t1_cnt", 0, 32'(ocnt[0]), 32'd1);
        tick();
        look();
        chk("t1_cnt_after_pop", 0, 32'(ocnt[0]), 32'd0);
        tick();
        send(0, 8'hC); send(0, 8'h1); send(0, 8'h2); send(0, 8'h7);
        look();
        chk("t2_no_vld", 0, 32'(o_vld[0]), 32'd0);
        tick();
        send(0, 8'hB); send(0, 8'hE); send(0, 8'hE); send(0, 8'hF);
        look();
        chk("t2_insn", 0, 32'(o_insn[0]), 32'hC127);
        chk("t2_imm", 0, 32'(o_imm[0]), 32'hBEEF);
        chk("t2_imm_vld", 0, 32'(o_iv[0]), 32'd1);
        tick();

        // Backpressure at full: non-completing beats pass, completing beat stalls
        rdy[0] = 1'b0;
        send_word(0, 16'h1000);
        send_word(0, 16'h2000);
        look();
        chk("t3_full_cnt", 0, 32'(ocnt[0]), 32'd2);
        tick();
        send(0, 8'h3); send(0, 8'h0); send(0, 8'h0);
        bvld[0] = 1'b1; beat[0] = 8'h0;
        look();
        chk("t3_stall", 0, 32'(o_rdy[0]), 32'd0);
        tick();
        rdy[0] = 1'b1;
        look();
        chk("t3_no_same_cycle_rdy", 0, 32'(o_rdy[0]), 32'd0);
        chk("t3_head", 0, 32'(o_insn[0]), 32'h1000);
        tick();
        rdy[0] = 1'b0;
        look();
        chk("t3_rdy_after_pop", 0, 32'(o_rdy[0]), 32'd1);
        chk("t3_cnt_after_pop", 0, 32'(ocnt[0]), 32'd1);
        tick();
        bvld[0] = 1'b0;
        look();
        chk("t3_cnt_refill", 0, 32'(ocnt[0]), 32'd2);
        chk("t3_head2", 0, 32'(o_insn[0]), 32'h2000);
        tick();
        rdy[0] = 1'b1;
        step(); step();

        // Flush mid-immediate
        send(0, 8'hC); send(0, 8'h1); send(0, 8'h2); send(0, 8'h7); send(0, 8'hB); send(0, 8'hE);
        bvld[0] = 1'b1; beat[0] = 8'hE; fl[0] = 1'b1;
        look();
        chk("t4_flush_rdy", 0, 32'(o_rdy[0]), 32'd0);
        chk("t4_flush_vld", 0, 32'(o_vld[0]), 32'd0);
        tick();
        bvld[0] = 1'b0; fl[0] = 1'b0;
        look();
        chk("t4_cnt", 0, 32'(ocnt[0]), 32'd0);
        tick();
        rdy[0] = 1'b0;
        send_word(0, 16'h1234);
        look();
        chk("t4_insn", 0, 32'(o_insn[0]), 32'h1234);
        chk("t4_imm_vld", 0, 32'(o_iv[0]), 32'd0);
        chk("t4_cnt1", 0, 32'(ocnt[0]), 32'd1);
        rdy[0] = 1'b1;
        tick();

        // Exclusion rule
        rdy[1] = 1'b1;
        send_word(1, 16'hB00F);
        look();
        chk("t5_excl_insn", 1, 32'(o_insn[1]), 32'hB00F);
        chk("t5_excl_imm_vld", 1, 32'(o_iv[1]), 32'd0);
        tick();
        send_word(1, 16'hA00F);
        look();
        chk("t5_wait_imm", 1, 32'(o_vld[1]), 32'd0);
        tick();
        send_word(1, 16'h0055);
        look();
        chk("t5_pair_insn", 1, 32'(o_insn[1]), 32'hA00F);
        chk("t5_pair_imm", 1, 32'(o_imm[1]), 32'h0055);
        chk("t5_pair_imm_vld", 1, 32'(o_iv[1]), 32'd1);
        tick();

        // 8-bit lanes, single-entry queue
        rdy[2] = 1'b1;
        send(2, 8'hC1); send(2, 8'h27); send(2, 8'h12); send(2, 8'h34);
        look();
        chk("t6_vld", 2, 32'(o_vld[2]), 32'd1);
        chk("t6_insn", 2, 32'(o_insn[2]), 32'hC127);
        chk("t6_imm", 2, 32'(o_imm[2]), 32'h1234);
        chk("t6_imm_vld", 2, 32'(o_iv[2]), 32'd1);
        rdy[2] = 1'b0;
        tick();
        send(2, 8'h56);
        bvld[2] = 1'b1; beat[2] = 8'h78;
        look();
        chk("t6_stall", 2, 32'(o_rdy[2]), 32'd0);
        tick();
        rdy[2] = 1'b1;
        look();
        chk("t6_stall_on_pop", 2, 32'(o_rdy[2]), 32'd0);
        tick();
        rdy[2] = 1'b0;
        look();
        chk("t6_rdy_after_pop", 2, 32'(o_rdy[2]), 32'd1);
        tick();
        bvld[2] = 1'b0;
        look();
        chk("t6_insn2", 2, 32'(o_insn[2]), 32'h5678);
        chk("t6_cnt", 2, 32'(ocnt[2]), 32'd1);
        rdy[2] = 1'b1;
        tick();

        // Randomized soak with a reset in the middle
        for (int n = 0; n < 3000; n++) begin
            rst = (n == 1500);
            for (int i = 0; i < 3; i++) begin
                bvld[i] = ($urandom_range(0, 9) < 7);
                beat[i] = 8'($urandom);
                if ($urandom_range(0, 3) == 0) beat[i] = beat[i] | 8'h07;
                fl[i]   = ($urandom_range(0, 39) == 0);
                rdy[i]  = ($urandom_range(0, 1) == 1);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
